// File: rtl/tdc_pkg.sv
// Shared geometry of the TDC delay line: ring length and TOT tap layout.
package tdc_pkg;

    localparam int NUM_CELLS  = 63;
    localparam int TOT_TAPS   = 21;
    localparam int TOT_STRIDE = 3;
    localparam int TOT_OFFSET = 2;

    // Ring cell index sampled by TOT bit k.
    function automatic int tot_tap_index(input int k);
        return TOT_OFFSET + TOT_STRIDE * k;
    endfunction

endpackage

// File: rtl/tdc_edge_capture.sv
// Rising-edge detector on a synchronous strobe plus a capture register.
// The word presented on data_i at the detecting edge is held until the next rise.
module tdc_edge_capture #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         strobe_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] data_o
);

    logic         prev_q;
    logic [W-1:0] cap_q;
    logic [W-1:0] cap_d;
    logic         rise;

    // A held-high strobe fires once; a low cycle is needed to re-arm.
    assign rise = strobe_i & ~prev_q;

    // Load the snapshot on a strobe rise, otherwise hold.
    always_comb begin
        cap_d = cap_q;
        if (rise) begin
            cap_d = data_i;
        end
    end

    // Previous-strobe and capture state; prev resets low so a strobe already
    // high after reset release counts as a rise.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_q <= 1'b0;
            cap_q  <= '0;
        end else begin
            prev_q <= strobe_i;
            cap_q  <= cap_d;
        end
    end

    assign data_o = cap_q;

endmodule

// File: rtl/tdc_delay_line.sv
// Cycle-level ETROC2 TDC delay line: a ring of inverting-feedback delay cells
// launched by Start, sampled by the TOA strobe (all cells) and the TOT strobe
// (every third cell). One Clk edge models one cell propagation step.
module tdc_delay_line
    import tdc_pkg::*;
(
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Start,
    input  logic                 TOA_Clk,
    input  logic                 TOT_Clk,
    output logic [NUM_CELLS-1:0] TOARawData,
    output logic [TOT_TAPS-1:0]  TOTRawData,
    output logic                 Counter_Clk
);

    logic [NUM_CELLS-1:0] ring_q;
    logic [NUM_CELLS-1:0] ring_d;
    logic [TOT_TAPS-1:0]  tot_taps;

    // Shift toward the last cell; the inverted last cell re-enters cell 0 only
    // while Start is high, so the ring free-runs with a 2*NUM_CELLS period and
    // drains to zero once Start drops.
    always_comb begin
        ring_d = {ring_q[NUM_CELLS-2:0], Start & ~ring_q[NUM_CELLS-1]};
    end

    // Ring state register.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            ring_q <= '0;
        end else begin
            ring_q <= ring_d;
        end
    end

    // The last cell is the oscillator output that clocks the coarse counter.
    assign Counter_Clk = ring_q[NUM_CELLS-1];

    // TOT samples a strided subset of the cells.
    for (genvar k = 0; k < TOT_TAPS; k++) begin : g_tot_tap
        assign tot_taps[k] = ring_q[tot_tap_index(k)];
    end

    // Both captures see the pre-shift ring, so coincident strobes agree.
    tdc_edge_capture #(.W(NUM_CELLS)) u_toa_cap (
        .clk_i   (Clk),
        .rst_i   (Rst),
        .strobe_i(TOA_Clk),
        .data_i  (ring_q),
        .data_o  (TOARawData)
    );

    tdc_edge_capture #(.W(TOT_TAPS)) u_tot_cap (
        .clk_i   (Clk),
        .rst_i   (Rst),
        .strobe_i(TOT_Clk),
        .data_i  (tot_taps),
        .data_o  (TOTRawData)
    );

endmodule

// File: tb/tb_tdc_delay_line.sv
// Directed bench for tdc_delay_line with hand-computed expected words.
module tb_tdc_delay_line;

    logic        Clk;
    logic        Rst;
    logic        Start;
    logic        TOA_Clk;
    logic        TOT_Clk;
    logic [62:0] TOARawData;
    logic [20:0] TOTRawData;
    logic        Counter_Clk;

    int total;
    int bad;

    tdc_delay_line dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .Start      (Start),
        .TOA_Clk    (TOA_Clk),
        .TOT_Clk    (TOT_Clk),
        .TOARawData (TOARawData),
        .TOTRawData (TOTRawData),
        .Counter_Clk(Counter_Clk)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    // Assert reset asynchronously, check that everything cleared at once,
    // then release 1 time unit after the next edge.
    task automatic do_reset(input string tag);
        Rst = 1'b1;
        #1;
        chk({tag, "_toa"}, {1'b0, TOARawData}, 64'h0);
        chk({tag, "_tot"}, {43'h0, TOTRawData}, 64'h0);
        chk({tag, "_cnt"}, {63'h0, Counter_Clk}, 64'h0);
        @(posedge Clk);
        #1;
        Rst = 1'b0;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        Rst     = 1'b1;
        Start   = 1'b1;
        TOA_Clk = 1'b1;
        TOT_Clk = 1'b1;
        #1;
        chk("rst0_toa", {1'b0, TOARawData}, 64'h0);
        chk("rst0_tot", {43'h0, TOTRawData}, 64'h0);
        chk("rst0_cnt", {63'h0, Counter_Clk}, 64'h0);
        step(2);

        // Strobes already high at reset release: first edge captures empty ring.
        Rst = 1'b0;
        step(1);
        chk("rel_toa", {1'b0, TOARawData}, 64'h0);
        chk("rel_tot", {43'h0, TOTRawData}, 64'h0);
        step(4);   // strobes still held: no further capture
        chk("rel_hold_toa", {1'b0, TOARawData}, 64'h0);
        TOA_Clk = 1'b0;
        TOT_Clk = 1'b0;
        step(1);   // ring now has 6 ones
        TOA_Clk = 1'b1;
        TOT_Clk = 1'b1;
        step(1);
        chk("rearm_toa", {1'b0, TOARawData}, 64'h3F);
        chk("rearm_tot", {43'h0, TOTRawData}, 64'h3);
        TOA_Clk = 1'b0;
        TOT_Clk = 1'b0;

        // Reset mid-operation with Start high and nonzero captures.
        do_reset("midrst");
        Start = 1'b0;
        step(3);
        chk("post_rst_toa", {1'b0, TOARawData}, 64'h0);
        chk("post_rst_cnt", {63'h0, Counter_Clk}, 64'h0);

        // Short run: 10 edges, then coincident TOA/TOT rise.
        do_reset("short");
        Start = 1'b1;
        step(10);
        Start   = 1'b0;
        TOA_Clk = 1'b1;
        TOT_Clk = 1'b1;
        step(1);
        chk("short_toa", {1'b0, TOARawData}, 64'h3FF);
        chk("short_tot", {43'h0, TOTRawData}, 64'h7);
        chk("short_cnt", {63'h0, Counter_Clk}, 64'h0);
        TOA_Clk = 1'b0;
        TOT_Clk = 1'b0;

        // Wrap-around: 70 edges then TOA capture; Counter_Clk window 63..125.
        do_reset("wrap");
        Start = 1'b1;
        step(62);
        chk("wrap_cnt62", {63'h0, Counter_Clk}, 64'h0);
        step(1);
        chk("wrap_cnt63", {63'h0, Counter_Clk}, 64'h1);
        step(7);   // 70 edges
        TOA_Clk = 1'b1;
        step(1);   // edge 71
        chk("wrap_toa", {1'b0, TOARawData}, 64'h7FFF_FFFF_FFFF_FF80);
        chk("wrap_tot", {43'h0, TOTRawData}, 64'h0);
        TOA_Clk = 1'b0;
        step(54);  // edge 125
        chk("wrap_cnt125", {63'h0, Counter_Clk}, 64'h1);
        step(1);   // edge 126
        chk("wrap_cnt126", {63'h0, Counter_Clk}, 64'h0);
        step(1);   // edge 127: ones start refilling from cell 0
        chk("wrap_cnt127", {63'h0, Counter_Clk}, 64'h0);

        // Stop/drain: fill to all ones, capture while Start drops, drain 63.
        do_reset("drain");
        Start = 1'b1;
        step(63);
        chk("drain_full_cnt", {63'h0, Counter_Clk}, 64'h1);
        Start   = 1'b0;
        TOA_Clk = 1'b1;
        TOT_Clk = 1'b1;
        step(1);   // drain edge 1
        chk("drain_full_toa", {1'b0, TOARawData}, 64'h7FFF_FFFF_FFFF_FFFF);
        chk("drain_full_tot", {43'h0, TOTRawData}, 64'h1F_FFFF);
        TOA_Clk = 1'b0;
        TOT_Clk = 1'b0;
        step(61);  // drain edge 62
        chk("drain_cnt62", {63'h0, Counter_Clk}, 64'h1);
        step(1);   // drain edge 63
        chk("drain_cnt63", {63'h0, Counter_Clk}, 64'h0);
        step(5);
        chk("drain_quiet_cnt", {63'h0, Counter_Clk}, 64'h0);
        TOA_Clk = 1'b1;
        TOT_Clk = 1'b1;
        step(1);
        chk("drain_toa", {1'b0, TOARawData}, 64'h0);
        chk("drain_tot", {43'h0, TOTRawData}, 64'h0);
        TOA_Clk = 1'b0;
        TOT_Clk = 1'b0;

        // Held strobe: one capture over 20 high cycles, recapture after low.
        do_reset("held");
        Start = 1'b1;
        step(5);
        TOA_Clk = 1'b1;
        step(1);   // captures ring after 5 edges
        chk("held_first", {1'b0, TOARawData}, 64'h1F);
        step(19);
        chk("held_still", {1'b0, TOARawData}, 64'h1F);
        TOA_Clk = 1'b0;
        step(1);   // 26 edges total
        TOA_Clk = 1'b1;
        step(1);
        chk("held_recap", {1'b0, TOARawData}, 64'h3FF_FFFF);
        chk("held_tot", {43'h0, TOTRawData}, 64'h0);
        TOA_Clk = 1'b0;

        // TOT alone: 30 edges, taps 2,5,...,29 -> bits 0..9.
        do_reset("totonly");
        step(30);
        TOT_Clk = 1'b1;
        step(1);
        chk("totonly_tot", {43'h0, TOTRawData}, 64'h3FF);
        chk("totonly_toa", {1'b0, TOARawData}, 64'h0);
        TOT_Clk = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tdc_delay_line.md
# tdc_delay_line

Cycle-level model of the ETROC2 TDC delay line: a 63-cell ring oscillator launched by `Start`, whose tap state is captured by the TOA strobe (all 63 taps) and the TOT strobe (21 taps). It feeds the raw thermometer-code words and the coarse-counter clock to the TDC encoder and ripple-counter blocks. One `Clk` period represents one delay-cell propagation step.

## Interface
- `NUM_CELLS`, 63: ring length, equal to the TOA raw width.
- `TOT_TAPS`, 21: TOT raw width.
- `TOT_STRIDE`, 3: tap spacing for TOT sampling.
- `TOT_OFFSET`, 2: first TOT tap index.
- `Clk` input 1: single clock; rising edge = one cell delay step.
- `Rst` input 1: reset, asynchronous, active-high.
- `Start` input 1: level, synchronous to `Clk`; ring runs while high.
- `TOA_Clk` input 1: TOA capture strobe, synchronous level; rising edge triggers capture.
- `TOT_Clk` input 1: TOT capture strobe, synchronous level; rising edge triggers capture.
- `TOARawData` output 63: captured ring state, bit i = cell i.
- `TOTRawData` output 21: captured taps, bit k = cell `TOT_OFFSET + TOT_STRIDE*k` (cells 2, 5, …, 62).
- `Counter_Clk` output 1: ring output, equal to cell 62, drives the coarse counter.

## Operation
- Ring register `ring[62:0]`. On each `Clk` edge: `ring <= {ring[61:0], Start & ~ring[62]}`.
- With `Start` high from an all-zero ring, ones fill from cell 0. After 63 steps the ring is all ones, then zeros propagate. Free-running period is 126 `Clk` cycles.
- With `Start` low, zeros enter cell 0. The ring drains to all-zero within 63 cycles and then stays quiet.
- `Counter_Clk` = `ring[62]`, combinational from the register with no extra logic.
- TOA capture: a register holds the previous `TOA_Clk`. When `TOA_Clk`=1 and prev=0 at a `Clk` edge, `TOARawData <= ring`, using the pre-shift value at that edge. `TOARawData` holds until the next rising edge.
- TOT capture: same rule with `TOT_Clk`. `TOTRawData[k] <= ring[2+3k]`.
- TOA and TOT edges in the same cycle both capture the same ring snapshot.
- Strobe held high: only one capture occurs. A new capture requires a low cycle first.

## Timing
- Reset values: `ring`=0, `TOARawData`=0, `TOTRawData`=0, `Counter_Clk`=0, prev-strobe registers=0.
- Because the prev-strobe registers reset to 0, a strobe already high at the first edge after reset release counts as a rising edge.
- Capture latency: the captured word is visible after the `Clk` edge that detects the strobe rise (1 cycle).
- N consecutive edges with `Start` sampled high from an empty ring, followed by a capture edge: captured word = ring after those N edges.
- Wrap-around: for 63 < N ≤ 126, the low (N−63) cells are 0 and the rest are 1.
- Reset asserted mid-operation: all state clears immediately (asynchronous), with no partial capture.

## Structure
- Shared package `tdc_pkg` holds `NUM_CELLS`, `TOT_TAPS`, `TOT_STRIDE` and `TOT_OFFSET`.
- One sub-module, `tdc_edge_capture`, parameterised by width: rising-edge detect plus capture register. It is instantiated twice (TOA, TOT).
- The TOT tap selection is a generate loop in the top module.

## Test plan
- Reset: assert `Rst` with `Start`=1 running; all outputs are 0 immediately. Release: outputs stay 0 until `Start` and strobe activity.
- TOA/TOT short: `Start` high for 10 edges, then `TOA_Clk` and `TOT_Clk` rise together. Expect `TOARawData`=63'h3FF and `TOTRawData`=21'h7.
- Wrap: `Start` high for 70 edges, then TOA capture. Expect `TOARawData`=63'h7FFF_FFFF_FFFF_FF80. `Counter_Clk` is 1 from edge 63 through edge 125 and 0 at edge 126.
- Stop/drain: `Start` low after 63 edges, with the ring all ones. Expect `Counter_Clk`=0 and `ring`=0 after 63 more edges; a capture then gives 0.
- Held strobe: `TOA_Clk` held high for 20 cycles while the ring runs. `TOARawData` changes only once. After a low cycle and a re-rise, it recaptures.
- Strobe high at reset release: `TOA_Clk`=1 when `Rst` drops. Capture occurs at the first edge, giving 0 with an empty ring.
